// File: rtl/r4_fft_sequencer.sv
// r4_fft_sequencer: frames four complex samples into an external radix-4
// butterfly, steps the butterfly through k=0..3 and drains the four results.
//
// Ports:
//   CLK, RST            clock, async active-low reset
//   flush               synchronous abort of the current frame
//   in_valid/in_ready   sample input handshake, in_re/in_im payload
//   xr0..xr3, xi0..xi3  butterfly operand registers
//   c1, c2, c3          butterfly control: k[0], k[1], compute enable
//   Xro, Xio            butterfly result for the current k
//   out_valid/out_ready result output handshake, out_re/out_im payload
//   busy                high while computing or draining
module r4_fft_sequencer #(
  parameter int unsigned LAT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [3:0] in_re,
  input  logic [3:0] in_im,
  output logic       in_ready,
  output logic [3:0] xr0,
  output logic [3:0] xr1,
  output logic [3:0] xr2,
  output logic [3:0] xr3,
  output logic [3:0] xi0,
  output logic [3:0] xi1,
  output logic [3:0] xi2,
  output logic [3:0] xi3,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  input  logic [3:0] Xro,
  input  logic [3:0] Xio,
  output logic       out_valid,
  output logic [3:0] out_re,
  output logic [3:0] out_im,
  input  logic       out_ready,
  output logic       busy
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {LOAD, COMP, DRAIN} state_t;

  state_t        state, state_d;
  logic [CW-1:0] n_q, n_d, k_q, k_d, cyc_q, cyc_d, j_q, j_d;
  logic [CW-1:0] k_nx, j_nx;
  logic [DW-1:0] xr_q [4];
  logic [DW-1:0] xi_q [4];
  logic [DW-1:0] rb_re [4];
  logic [DW-1:0] rb_im [4];
  logic          in_ready_d, c1_d, c2_d, c3_d, out_valid_d, busy_d;
  logic [DW-1:0] out_re_d, out_im_d;
  logic          load_en, cap_en;

  assign xr0 = xr_q[0];
  assign xr1 = xr_q[1];
  assign xr2 = xr_q[2];
  assign xr3 = xr_q[3];
  assign xi0 = xi_q[0];
  assign xi1 = xi_q[1];
  assign xi2 = xi_q[2];
  assign xi3 = xi_q[3];

  // Next-state and next-output logic; every output is the registered copy of its _d.
  always_comb begin
    state_d     = state;
    n_d         = n_q;
    k_d         = k_q;
    cyc_d       = cyc_q;
    j_d         = j_q;
    in_ready_d  = in_ready;
    c1_d        = c1;
    c2_d        = c2;
    c3_d        = c3;
    out_valid_d = out_valid;
    out_re_d    = out_re;
    out_im_d    = out_im;
    load_en     = 1'b0;
    cap_en      = 1'b0;
    k_nx        = k_q + 2'd1;
    j_nx        = j_q + 2'd1;

    if (flush) begin
      // Flush wins over any handshake presented in the same cycle.
      state_d     = LOAD;
      n_d         = '0;
      k_d         = '0;
      cyc_d       = '0;
      j_d         = '0;
      in_ready_d  = 1'b1;
      c1_d        = 1'b0;
      c2_d        = 1'b0;
      c3_d        = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          in_ready_d = 1'b1;
          if (in_valid && in_ready) begin
            load_en = 1'b1;
            n_d     = n_q + 2'd1;
            if (n_q == 2'd3) begin
              state_d    = COMP;
              in_ready_d = 1'b0;
              k_d        = '0;
              cyc_d      = '0;
              c1_d       = 1'b0;
              c2_d       = 1'b0;
              c3_d       = 1'b1;
            end
          end
        end
        COMP: begin
          in_ready_d = 1'b0;
          c3_d       = 1'b1;
          c1_d       = k_q[0];
          c2_d       = k_q[1];
          // Last cycle of this k: butterfly output is settled, capture it.
          if (cyc_q == CW'(LAT)) begin
            cap_en = 1'b1;
            cyc_d  = '0;
            if (k_q == 2'd3) begin
              state_d = DRAIN;
              k_d     = '0;
              j_d     = '0;
              c1_d    = 1'b0;
              c2_d    = 1'b0;
              c3_d    = 1'b0;
            end else begin
              k_d  = k_nx;
              c1_d = k_nx[0];
              c2_d = k_nx[1];
            end
          end else begin
            cyc_d = cyc_q + 2'd1;
          end
        end
        DRAIN: begin
          in_ready_d  = 1'b0;
          c1_d        = 1'b0;
          c2_d        = 1'b0;
          c3_d        = 1'b0;
          out_valid_d = 1'b1;
          out_re_d    = rb_re[j_q];
          out_im_d    = rb_im[j_q];
          if (out_valid && out_ready) begin
            j_d = j_nx;
            if (j_q == 2'd3) begin
              state_d     = LOAD;
              out_valid_d = 1'b0;
              in_ready_d  = 1'b1;
            end else begin
              out_re_d = rb_re[j_nx];
              out_im_d = rb_im[j_nx];
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
    busy_d = (state_d != LOAD);
  end

  // State, counters, operand/result storage and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= LOAD;
      n_q       <= '0;
      k_q       <= '0;
      cyc_q     <= '0;
      j_q       <= '0;
      in_ready  <= 1'b0;
      c1        <= 1'b0;
      c2        <= 1'b0;
      c3        <= 1'b0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        xr_q[i]  <= '0;
        xi_q[i]  <= '0;
        rb_re[i] <= '0;
        rb_im[i] <= '0;
      end
    end else begin
      state     <= state_d;
      n_q       <= n_d;
      k_q       <= k_d;
      cyc_q     <= cyc_d;
      j_q       <= j_d;
      in_ready  <= in_ready_d;
      c1        <= c1_d;
      c2        <= c2_d;
      c3        <= c3_d;
      out_valid <= out_valid_d;
      out_re    <= out_re_d;
      out_im    <= out_im_d;
      busy      <= busy_d;
      if (load_en) begin
        xr_q[n_q] <= in_re;
        xi_q[n_q] <= in_im;
      end
      if (cap_en) begin
        rb_re[k_q] <= Xro;
        rb_im[k_q] <= Xio;
      end
    end
  end

endmodule

// File: tb/tb_r4_fft_sequencer.sv
// Testbench for r4_fft_sequencer (LAT=1) with a one-cycle butterfly stub:
// Xro={c3,c2,c1,1}, Xio=xr0. Results are scoreboarded through a queue.
module tb_r4_fft_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_re = '0;
  logic [3:0] in_im = '0;
  logic       in_ready;
  logic [3:0] xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3;
  logic       c1, c2, c3;
  logic [3:0] Xro, Xio;
  logic       out_valid;
  logic [3:0] out_re, out_im;
  logic       out_ready = 1'b0;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;
  int cyc_cnt = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic [3:0][3:0] re;
    logic [3:0][3:0] im;
    int              stall_j;
    int              stall_len;
    logic [3:0][3:0] exp_re;
    logic [3:0]      exp_im;
  } vec_t;

  vec_t tbl [3];
  logic [3:0] samp [6];

  r4_fft_sequencer #(.LAT(1)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_re(in_re), .in_im(in_im), .in_ready(in_ready),
    .xr0(xr0), .xr1(xr1), .xr2(xr2), .xr3(xr3),
    .xi0(xi0), .xi1(xi1), .xi2(xi2), .xi3(xi3),
    .c1(c1), .c2(c2), .c3(c3),
    .Xro(Xro), .Xio(Xio),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  // Butterfly stub, one cycle of latency.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Xro <= '0;
      Xio <= '0;
    end else begin
      Xro <= {c3, c2, c1, 1'b1};
      Xio <= xr0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A handshake seen here completes on the next rising edge.
  always @(negedge CLK) begin
    if (RST && !flush && out_valid && out_ready) begin
      n_out++;
      check("unexpected_out", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        logic [7:0] e;
        e = sb.pop_front();
        check("out_re", 32'(out_re), 32'(e[7:4]));
        check("out_im", 32'(out_im), 32'(e[3:0]));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    int budget = 50;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    check("wait_in_ready", 32'(in_ready), 1);
  endtask

  task automatic load4(input vec_t v, output int e3);
    wait_ready();
    for (int i = 0; i < 4; i++) begin
      in_re    = v.re[i];
      in_im    = v.im[i];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    e3 = cyc_cnt;
  endtask

  task automatic run_frame(input vec_t v);
    int  e3, base, budget;
    bit  stalled;
    base = n_out;
    load4(v, e3);
    for (int i = 0; i < 4; i++) sb.push_back({v.exp_re[i], v.exp_im});
    check("xr_loaded", 32'({xr3, xr2, xr1, xr0}), 32'(v.re));
    check("xi_loaded", 32'({xi3, xi2, xi1, xi0}), 32'(v.im));
    for (int m = 0; m < 8; m++) begin
      check("c_seq", 32'({c3, c2, c1}), 32'({1'b1, 2'(m / 2)}));
      check("comp_flags", 32'({busy, in_ready, out_valid}), 32'(3'b100));
      tick();
    end
    check("drain_entry", 32'({c3, c2, c1, out_valid, busy}), 32'(5'b00001));
    budget = 20;
    while (!out_valid && budget > 0) begin
      tick();
      budget--;
    end
    check("first_latency", 32'(cyc_cnt - e3), 9);
    stalled = 1'b0;
    budget  = 60;
    while ((n_out - base) < 4 && budget > 0) begin
      if (!stalled && (n_out - base) == v.stall_j) begin
        out_ready = 1'b0;
        for (int s = 0; s < v.stall_len; s++) begin
          tick();
          check("stall_hold", 32'({out_valid, in_ready, out_re}),
                32'({1'b1, 1'b0, v.exp_re[v.stall_j]}));
        end
        out_ready = 1'b1;
        stalled   = 1'b1;
      end
      tick();
      budget--;
    end
    check("drain_count", 32'(n_out - base), 4);
    check("back_to_load", 32'({in_ready, busy, out_valid, c3}), 32'(4'b1000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int  e3, base, idx, budget;
    bit  acc, seen;
    vec_t fv;

    tbl[0].re = {4'd4, 4'd3, 4'd2, 4'd1};
    tbl[0].im = '0;
    tbl[0].stall_j = -1;
    tbl[0].stall_len = 0;
    tbl[0].exp_re = {4'b1111, 4'b1101, 4'b1011, 4'b1001};
    tbl[0].exp_im = 4'd1;
    tbl[1] = tbl[0];
    tbl[1].stall_j = 2;
    tbl[1].stall_len = 5;
    tbl[2].re = {4'd0, 4'd5, 4'd8, 4'd7};
    tbl[2].im = {4'd4, 4'd3, 4'd2, 4'd1};
    tbl[2].stall_j = 0;
    tbl[2].stall_len = 2;
    tbl[2].exp_re = {4'b1111, 4'b1101, 4'b1011, 4'b1001};
    tbl[2].exp_im = 4'd7;
    samp = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    // Reset values
    repeat (3) @(posedge CLK);
    #2;
    check("rst_flags", 32'({in_ready, out_valid, busy, c3, c2, c1}), 0);
    check("rst_xr", 32'({xr3, xr2, xr1, xr0}), 0);
    check("rst_out", 32'({out_re, out_im}), 0);
    RST = 1'b1;
    #1;
    check("rel_in_ready_low", 32'(in_ready), 0);
    tick();
    check("rel_in_ready_high", 32'({in_ready, busy}), 32'(2'b10));
    out_ready = 1'b1;

    // Table-driven frames
    for (int t = 0; t < 3; t++) run_frame(tbl[t]);

    // in_valid held high over six samples
    base = n_out;
    idx = 0;
    budget = 200;
    in_valid = 1'b1;
    while (idx < 6 && budget > 0) begin
      in_re = samp[idx];
      in_im = 4'(idx);
      acc = in_ready;
      tick();
      budget--;
      if (acc) begin
        idx++;
        if (idx == 4) begin
          for (int i = 0; i < 4; i++) sb.push_back({tbl[0].exp_re[i], 4'd10});
          check("six_first4", 32'({xr3, xr2, xr1, xr0}), 32'({4'd13, 4'd12, 4'd11, 4'd10}));
        end
        if (idx == 5) begin
          check("six_5th_after_drain", 32'(n_out - base), 4);
          check("six_5th_slot", 32'({xr3, xr2, xr1, xr0}), 32'({4'd13, 4'd12, 4'd11, 4'd14}));
        end
        if (idx == 6) check("six_6th_slot", 32'(xr1), 32'(4'd15));
      end
    end
    in_valid = 1'b0;
    check("six_done", 32'(idx), 6);

    // Flush in LOAD beats a simultaneous input beat
    in_valid = 1'b1;
    in_re = 4'd9;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_load_no_write", 32'(xr2), 32'(4'd12));
    check("flush_load_flags", 32'({in_ready, busy}), 32'(2'b10));
    run_frame(tbl[2]);

    // Flush in the third COMP cycle
    fv = tbl[0];
    fv.re = {4'd8, 4'd7, 4'd6, 4'd5};
    load4(fv, e3);
    tick();
    tick();
    check("pre_flush_c3", 32'(c3), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_comp", 32'({c3, c2, c1, busy, out_valid, in_ready}), 32'(6'b000001));
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_out", 32'(seen), 0);
    run_frame(tbl[0]);

    // Async reset during DRAIN at j=1
    base = n_out;
    load4(tbl[0], e3);
    for (int i = 0; i < 4; i++) sb.push_back({tbl[0].exp_re[i], tbl[0].exp_im});
    budget = 40;
    while ((n_out - base) < 1 && budget > 0) begin
      tick();
      budget--;
    end
    check("rst_drain_reached", 32'({out_valid, 2'(n_out - base)}), 32'({1'b1, 2'd1}));
    #2;
    RST = 1'b0;
    #1;
    check("rst_async", 32'({out_valid, busy, in_ready, c3, c2, c1}), 0);
    check("rst_async_xr", 32'({xr3, xr2, xr1, xr0}), 0);
    sb.delete();
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("rst2_in_ready_low", 32'(in_ready), 0);
    tick();
    check("rst2_release", 32'({in_ready, busy, out_valid, c3, c2, c1}), 32'(6'b100000));
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("rst2_no_partial", 32'(seen), 0);
    check("rst2_no_pop", 32'(n_out - base), 1);
    run_frame(tbl[1]);

    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/r4_fft_sequencer.md
R4_FFT_SEQUENCER -- requirements
Module: r4_fft_sequencer

Interface
REQ-001 Parameter: LAT, default 1, butterfly output latency in cycles (0..3) from xr*/xi*/c* change to valid Xro/Xio.
REQ-002 CLK  input  1  sole clock, all state on rising edge.
REQ-003 RST  input  1  reset, asynchronous assert, active-low; release synchronous to CLK.
REQ-004 flush  input  1  synchronous abort of the current frame.
REQ-005 in_valid  input  1  input sample offered.
REQ-006 in_re, in_im  input  4 each  input sample, two's complement.
REQ-007 in_ready  output  1  sequencer accepts a sample this cycle.
REQ-008 xr0..xr3, xi0..xi3  output  4 each  butterfly operand registers.
REQ-009 c1, c2, c3  output  1 each  butterfly control: c1=k[0], c2=k[1], c3=compute enable.
REQ-010 Xro, Xio  input  4 each  butterfly result for the current k.
REQ-011 out_valid  output  1  result sample available.
REQ-012 out_re, out_im  output  4 each  result sample X[k].
REQ-013 out_ready  input  1  consumer accepts a result.
REQ-014 busy  output  1  high in COMP or DRAIN.

Function
REQ-015 FSM states: LOAD, COMP, DRAIN; all outputs registered.
REQ-016 LOAD: in_ready=1; each in_valid&in_ready beat writes sample n (n=0..3, 2-bit count) to xr_n/xi_n.
REQ-017 The 4th accepted beat moves to COMP next cycle; count wraps to 0.
REQ-018 COMP: in_ready=0, c3=1; k steps 0,1,2,3; each k occupies LAT+1 cycles, presented with c1/c2 from its first cycle.
REQ-019 Result for k is captured from Xro/Xio on the edge ending the (LAT+1)th cycle of that k, into result buffer entry k.
REQ-020 After the k=3 capture: c3=0, c1=c2=0, enter DRAIN; COMP lasts exactly 4*(LAT+1) cycles.
REQ-021 DRAIN: out_valid=1, out_re/out_im = buffer[j], j=0..3; j advances on out_valid&out_ready; no advance while out_ready=0, data held stable.
REQ-022 The 4th DRAIN handshake returns to LOAD next cycle with in_ready=1; xr*/xi* retain last values until overwritten.
REQ-023 First out_valid occurs 1+4*(LAT+1) cycles after the edge accepting sample 3 (LAT=1: 9 cycles).
REQ-024 in_valid outside LOAD is ignored; no sample lost or overwritten.
REQ-025 flush in any state: next cycle LOAD, counts n/k/j=0, c1..c3=0, out_valid=0; buffer contents undefined to consumer; flush beats the simultaneous in_valid or out_ready handshake (that beat is not taken).
REQ-026 No arithmetic on data; widths pass unchanged; no saturation.

Reset
REQ-027 RST low: state LOAD, in_ready=0 during reset then 1 first cycle after release, out_valid=0, busy=0, c1=c2=c3=0, xr*/xi*=0, out_re/out_im=0, all counters 0.
REQ-028 RST assertion mid-COMP or mid-DRAIN aborts immediately with the REQ-027 values; no partial frame is emitted after release.

Verification
REQ-029 Bench butterfly stub (LAT=1): Xro={c3,c2,c1,1}, Xio=xr0, registered one cycle.
REQ-030 Load 1,2,3,4 (re) / 0 (im), out_ready=1 -> c sequence k=0..3 two cycles each, outputs re 4'b1001,1011,1101,1111, im 1, first out_valid 9 cycles after beat 3.
REQ-031 Same frame, out_ready low 5 cycles at j=2 -> out_re holds 4'b1101 stable; in_ready stays 0; completion with no duplicate or lost sample.
REQ-032 in_valid held high with 6 samples -> exactly the first 4 accepted; samples 5,6 are accepted only after DRAIN completes.
REQ-033 flush asserted at cycle 3 of COMP -> next cycle LOAD, c3=0, busy=0, no out_valid; a following clean frame produces correct results.
REQ-034 RST pulsed low during DRAIN at j=1 -> out_valid=0 immediately (asynchronous); after release in_ready=1, busy=0, all c*=0.
